// File: rtl/gates_checker.sv
// gates_checker: observes the basic-gates block (inputs A/B, outputs Z) and
// checks Z against the gate truth table. Over one run of NUM_VECTORS valid
// samples it accumulates a saturating error count, a sample count, per-input
// coverage, and the diagnostics of the first failing sample.
module gates_checker #(
    parameter int NUM_VECTORS = 4,
    parameter int ERR_W       = 8,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             valid,
    input  logic             A,
    input  logic             B,
    input  logic [5:0]       Z,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [CNT_W-1:0] vec_count,
    output logic [3:0]       coverage,
    output logic [1:0]       first_err_in,
    output logic [5:0]       first_err_mask
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    // Count value held when the final sample of a run is being checked.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

    state_t           state_q, state_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] vec_q, vec_d;
    logic [3:0]       cov_q, cov_d;
    logic [1:0]       fin_q, fin_d;
    logic [5:0]       fmask_q, fmask_d;
    logic             pass_q, pass_d;

    logic [5:0]       expected;
    logic [5:0]       diff;
    logic             mismatch;

    // Truth table: bit 5..0 = XNOR, XOR, NOR, OR, NAND, AND.
    assign expected = {~(A ^ B), A ^ B, ~(A | B), A | B, ~(A & B), A & B};
    assign diff     = Z ^ expected;
    // Case inequality so an X/Z on any Z bit is flagged as a mismatch in
    // simulation; synthesis treats this as ordinary inequality.
    assign mismatch = (Z !== expected);

    // Next-state and accumulator update; holds everything by default.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        vec_d   = vec_q;
        cov_d   = cov_q;
        fin_d   = fin_q;
        fmask_d = fmask_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    err_d   = '0;
                    vec_d   = '0;
                    cov_d   = '0;
                    fin_d   = '0;
                    fmask_d = '0;
                end
            end
            S_RUN: begin
                if (valid) begin
                    vec_d             = vec_q + CNT_W'(1);
                    cov_d[{B, A}]     = 1'b1;
                    if (mismatch) begin
                        if (err_q != {ERR_W{1'b1}}) begin
                            err_d = err_q + ERR_W'(1);
                        end
                        // Counter is still zero only before the first failure
                        // of the run (it saturates rather than wrapping).
                        if (err_q == '0) begin
                            fin_d   = {B, A};
                            fmask_d = diff;
                        end
                    end
                    if (vec_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        pass_d = (state_d == S_DONE) && (err_d == '0) && (cov_d == 4'hF);
    end

    // State and accumulator registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            err_q   <= '0;
            vec_q   <= '0;
            cov_q   <= '0;
            fin_q   <= '0;
            fmask_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            vec_q   <= vec_d;
            cov_q   <= cov_d;
            fin_q   <= fin_d;
            fmask_q <= fmask_d;
            pass_q  <= pass_d;
        end
    end

    assign busy           = (state_q == S_RUN);
    assign done           = (state_q == S_DONE);
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign vec_count      = vec_q;
    assign coverage       = cov_q;
    assign first_err_in   = fin_q;
    assign first_err_mask = fmask_q;

endmodule
